pixel_gray_convert: RTL and testbench

Streaming RGB565-to-8-bit-luminance converter sitting directly downstream of the camera capture stage. It accepts 16-bit RGB565 pixels with a frame-start strobe on a valid/ready handshake and emits 8-bit grey pixels tagged with frame coordinates (x, y), end-of-line and start-of-frame flags. It is the first stage of the SIFT front end, which consumes greyscale only.

---
 rtl/pixel_gray_convert.sv | 201 ++++++++++++++++++++
 tb/tb_pixel_gray_convert.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_gray_convert.sv
// Streaming RGB565 to 8-bit luminance converter: two-stage pipeline with a global
// stall, frame coordinate tagging and start-of-frame tracking. PIXEL_GRAY_WEIGHTED_EN selects BT.601 weights.
module pixel_gray_convert #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = 10,
    parameter int YW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sync,
    input  logic [15:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_eol,
    output logic          out_sync
);

    localparam int NCH = 3;
`ifdef PIXEL_GRAY_WEIGHTED_EN
    // S1 holds weighted products; the sum fits 16 bits and the luma is its top byte.
    localparam int TW  = 16;
    localparam int SW  = 16;
    localparam int GSH = 0;
    localparam int LSH = 8;
`else
    // S1 holds expanded channels; green counts twice, so a 10-bit sum divided by 4.
    localparam int TW  = 8;
    localparam int SW  = 10;
    localparam int GSH = 1;
    localparam int LSH = 2;
`endif

    logic          en;
    logic          accept;
    logic          sync_now;
    logic          last_x;
    logic          last_y;
    logic [XW-1:0] tag_x;
    logic [YW-1:0] tag_y;
    logic [7:0]    chan8 [NCH];
    logic [TW-1:0] term  [NCH];
    logic [SW-1:0] sum;
    logic [7:0]    luma;

    logic          sync_pend_q, sync_pend_d;
    logic [XW-1:0] x_cnt_q, x_cnt_d;
    logic [YW-1:0] y_cnt_q, y_cnt_d;

    logic          s1_valid_q, s1_valid_d;
    logic [TW-1:0] s1_term_q [NCH];
    logic [TW-1:0] s1_term_d [NCH];
    logic [XW-1:0] s1_x_q, s1_x_d;
    logic [YW-1:0] s1_y_q, s1_y_d;
    logic          s1_eol_q, s1_eol_d;
    logic          s1_sync_q, s1_sync_d;

    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [XW-1:0] out_x_q, out_x_d;
    logic [YW-1:0] out_y_q, out_y_d;
    logic          out_eol_q, out_eol_d;
    logic          out_sync_q, out_sync_d;

    // Replicate the channel MSBs into the vacated LSBs so full scale maps to 255.
    assign chan8[0] = {in_data[15:11], in_data[15:13]};
    assign chan8[1] = {in_data[10:5],  in_data[10:9]};
    assign chan8[2] = {in_data[4:0],   in_data[4:2]};

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_term
`ifdef PIXEL_GRAY_WEIGHTED_EN
            localparam logic [15:0] WT = (gi == 0) ? 16'd77 : ((gi == 1) ? 16'd150 : 16'd29);
            assign term[gi] = {8'd0, chan8[gi]} * WT;
`else
            assign term[gi] = chan8[gi];
`endif
        end
    endgenerate

    // Coordinate tagging and frame-start tracking on the input side.
    always_comb begin
        en          = out_ready | ~out_valid_q;
        accept      = in_valid & en;
        sync_now    = sync_pend_q | (in_sync & en);
        tag_x       = sync_now ? '0 : x_cnt_q;
        tag_y       = sync_now ? '0 : y_cnt_q;
        last_x      = (tag_x == XW'(WIDTH - 1));
        last_y      = (tag_y == YW'(HEIGHT - 1));
        sync_pend_d = sync_now;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        if (accept) begin
            sync_pend_d = 1'b0;
            if (last_x) begin
                x_cnt_d = '0;
                y_cnt_d = last_y ? '0 : tag_y + 1'b1;
            end else begin
                x_cnt_d = tag_x + 1'b1;
                y_cnt_d = tag_y;
            end
        end
    end

    // Stage 1: terms plus tags; bubbles enter as invalid slots.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_term_d  = s1_term_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_eol_d   = s1_eol_q;
        s1_sync_d  = s1_sync_q;
        if (en) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_term_d = term;
                s1_x_d    = tag_x;
                s1_y_d    = tag_y;
                s1_eol_d  = last_x;
                s1_sync_d = sync_now;
            end
        end
    end

    always_comb begin
        sum  = SW'(s1_term_q[0]) + (SW'(s1_term_q[1]) << GSH) + SW'(s1_term_q[2]);
        luma = 8'(sum >> LSH);
    end

    // Stage 2: output register, frozen while downstream stalls.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_eol_d   = out_eol_q;
        out_sync_d  = out_sync_q;
        if (en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = luma;
                out_x_d    = s1_x_q;
                out_y_d    = s1_y_q;
                out_eol_d  = s1_eol_q;
                out_sync_d = s1_sync_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_pend_q <= 1'b0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            s1_valid_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                s1_term_q[i] <= '0;
            end
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_eol_q    <= 1'b0;
            s1_sync_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_eol_q   <= 1'b0;
            out_sync_q  <= 1'b0;
        end else begin
            sync_pend_q <= sync_pend_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_term_q   <= s1_term_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_eol_q    <= s1_eol_d;
            s1_sync_q   <= s1_sync_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_eol_q   <= out_eol_d;
            out_sync_q  <= out_sync_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_eol   = out_eol_q;
    assign out_sync  = out_sync_q;

endmodule

// File: tb/tb_pixel_gray_convert.sv
// Scoreboard bench for pixel_gray_convert: a frame-index model predicts every output
// pixel; a separate monitor pops and compares on each output transfer.
module tb_pixel_gray_convert;

    localparam int W  = 20;
    localparam int H  = 6;
    localparam int XW = 10;
    localparam int YW = 10;

    typedef struct {
        int d;
        int x;
        int y;
        int eol;
        int sync;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sync = 1'b0;
    logic [15:0]   in_data = 16'd0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_eol;
    logic          out_sync;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    int   idx_m   = 0;
    bit   pend_m  = 1'b0;

    always #5 clk = ~clk;

    pixel_gray_convert #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sync(in_sync), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_eol(out_eol), .out_sync(out_sync)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int luma_ref(input logic [15:0] p);
        int r, g, b, r8, g8, b8;
        r  = int'(p[15:11]);
        g  = int'(p[10:5]);
        b  = int'(p[4:0]);
        r8 = r * 8 + r / 4;
        g8 = g * 4 + g / 16;
        b8 = b * 8 + b / 4;
`ifdef PIXEL_GRAY_WEIGHTED_EN
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
`else
        return (r8 + 2 * g8 + b8) / 4;
`endif
    endfunction

    // One clock of stimulus; the model follows the handshake and the frame index.
    task automatic cycle(input bit v, input logic [15:0] d, input bit s, input bit rdy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_sync   = s;
        out_ready = rdy;
        #1;
        if (!reset) begin
            chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (in_sync && in_ready) pend_m = 1'b1;
            if (in_valid && in_ready) begin
                e.sync = int'(pend_m);
                if (pend_m) idx_m = 0;
                pend_m = 1'b0;
                e.d   = luma_ref(d);
                e.x   = idx_m % W;
                e.y   = idx_m / W;
                e.eol = int'(e.x == W - 1);
                exp_q.push_back(e);
                idx_m = (idx_m + 1) % (W * H);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        exp_q.delete();
        idx_m  = 0;
        pend_m = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        reset = 1'b0;
    endtask

    // Monitor: pops on each transfer, and checks outputs hold across stalls.
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_d;
    logic [XW:0] prev_x;
    logic [YW:0] prev_y;
    logic        prev_eol, prev_sync;

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(prev_d));
                chk("hold_xy", int'({out_x, out_y}), int'({prev_x[XW-1:0], prev_y[YW-1:0]}));
                chk("hold_flags", int'({out_eol, out_sync}), int'({prev_eol, prev_sync}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] px data=%0d x=%0d y=%0d eol=%0d sync=%0d", out_data, out_x, out_y, out_eol, out_sync);
                    chk("out_data", int'(out_data), e.d);
                    chk("out_x", int'(out_x), e.x);
                    chk("out_y", int'(out_y), e.y);
                    chk("out_eol", int'(out_eol), e.eol);
                    chk("out_sync", int'(out_sync), e.sync);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
            prev_x    = {1'b0, out_x};
            prev_y    = {1'b0, out_y};
            prev_eol  = out_eol;
            prev_sync = out_sync;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_eol", int'(out_eol), 0);
        chk("rst_out_sync", int'(out_sync), 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("in_ready_after_reset", int'(in_ready), 1);

        // Latency and colour primaries
        cycle(1'b1, 16'hFFFF, 1'b0, 1'b1);
        cycle(1'b1, 16'h0000, 1'b0, 1'b1);
        chk("lat_one_edge", int'(out_valid), 0);
        cycle(1'b1, 16'hF800, 1'b0, 1'b1);
        chk("lat_two_edges", int'(out_valid), 1);
        chk("lat_data", int'(out_data), 255);
        cycle(1'b1, 16'h07E0, 1'b0, 1'b1);
        cycle(1'b1, 16'h001F, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Sync with a pixel, then more than a full frame to cover eol and y wrap
        cycle(1'b1, 16'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < W * H + W + 2; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b1);

        // Sync mid-line, sync without a pixel, and sync on a stalled cycle
        cycle(1'b1, 16'($urandom), 1'b1, 1'b1);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b1);

        // Random backpressure: continuous valid, then random valid and sync
        for (int i = 0; i < 1500; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 40) == 0),
                  1'($urandom_range(0, 1)));

        // Reset clears a pending sync
        repeat (3) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        do_reset();
        cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b1);

        // Reset with both stages full
        repeat (3) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        chk("full_before_reset", int'(out_valid), 1);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b1);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
